mealy_seq_1011_gen: RTL
=======================

Name: mealy_seq_1011_gen

Overview:
- Serial stimulus transmitter for the 1-bit Mealy sequence detectors; it is the driving end of the x/z serial link.
- Loads a parallel word and shifts it out MSB-first on x_out, one bit per clock, repeating the word a programmable number of times with no gaps.
- Runs an internal overlapping "1011" reference detector on its own output stream and reports the expected match count, so a bench can compare it against the detector-under-test's z pulses.

Parameters:
- WIDTH, 16, bits per loaded word.
- CNT_W, 8, width of repeat_n.
- MCW, 8, width of match_cnt (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a transfer; sampled only in IDLE.
- data_in  input  WIDTH  word to transmit; latched on accepted start.
- repeat_n  input  CNT_W  number of word repetitions; latched on accepted start; 0 is treated as 1.
- x_out  output  1  serial bit; 0 whenever x_valid=0.
- x_valid  output  1  high for every cycle a stream bit is on x_out.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  single-cycle pulse after the last bit.
- match_cnt  output  MCW  overlapping "1011" occurrences in the stream so far.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; x_out=0, x_valid=0, busy=0, done=0, match_cnt=0.
  - Shift register, bit counter, repeat counter and detector state all cleared.
  - Reset asserted mid-transfer aborts immediately; no done pulse is produced.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - start=1 at edge k: latch data_in and repeat_n (0 becomes 1); clear match_cnt and detector state; go to SHIFT.
  - At edge k: x_out=data_in[WIDTH-1], x_valid=1, busy=1.
- SHIFT:
  - Each edge advances one bit, MSB to LSB.
  - After bit 0 of a word, if repetitions remain, the latched word reloads and its MSB appears on the next cycle with no gap.
  - Total x_valid-high cycles = WIDTH × max(repeat_n,1).
  - After the final bit go to DONE: x_valid=0, x_out=0, done=1 for exactly one cycle.
- DONE: next edge goes to IDLE; done=0, busy=0.
- start: ignored while busy=1, including the DONE cycle; no queuing.
- data_in/repeat_n changes during a transfer have no effect.
- Reference detector:
  - Mealy, overlapping, states S0 (none), S1 ("1"), S2 ("10"), S3 ("101").
  - S0: 1→S1, 0→S0.
  - S1: 0→S2, 1→S1.
  - S2: 1→S3, 0→S0.
  - S3: 1→match, go to S1; 0→S2.
  - Evaluated on the bit present on x_out at each edge while x_valid=1.
  - match_cnt increments at that same edge and saturates at 2^MCW−1 (no wrap).
  - Detector state persists across word repetitions, so a match spanning a word boundary is counted.
  - match_cnt is final by the done cycle and holds until the next accepted start.

Test Plan:
- Single word, count check:
  - Stimulus: WIDTH=16, data_in=16'h5B6F (0101101101101111), repeat_n=1, start pulse.
  - Required: x_out sequence 0,1,0,1,1,0,1,1,0,1,1,0,1,1,1,1 on 16 consecutive x_valid cycles; done one cycle after the last bit; match_cnt=4.
- Cross-boundary match:
  - Stimulus: data_in=16'hC002, repeat_n=2.
  - Required: 32 valid bits with no gap between words; match_cnt=1 (the "10|11" boundary match).
  - With repeat_n=1 the same word gives match_cnt=0.
- Zero repeat:
  - Stimulus: repeat_n=0, data_in=16'h000B.
  - Required: exactly 16 valid bits; match_cnt=1; busy high for 17 cycles.
- Start while busy, then restart:
  - Stimulus: pulse start mid-transfer with a different data_in.
  - Required: no effect on the current stream.
  - A start in the cycle after done returns to IDLE is accepted; match_cnt clears to 0 at that edge.
- Reset mid-transfer:
  - Stimulus: drive rst=0 asynchronously at bit 7.
  - Required: x_valid, busy and match_cnt go to 0 immediately without waiting for a clock; no done pulse; a fresh start after release behaves normally.
- Saturation:
  - Stimulus: data_in=16'h5B6F, repeat_n=255.
  - Required: match_cnt stops at 255 and holds; done appears after 4080 valid bits.

Source files
------------

// File: rtl/mealy_seq_1011_gen.sv
// Serial stimulus transmitter for the 1-bit "1011" Mealy detectors.
// Shifts a latched word out MSB-first, repeated, and counts its own matches.
module mealy_seq_1011_gen #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8,
    parameter int MCW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [MCW-1:0]   match_cnt
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        S0,
        S1,
        S2,
        S3
    } det_t;

    state_t           state_q, state_d;
    det_t             det_q, det_d, det_nx;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] shifted;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] repcnt_q, repcnt_d;
    logic [MCW-1:0]   cnt_d;
    logic             xo_d, xv_d, busy_d, done_d;
    logic             hit;

    assign shifted = sreg_q << 1;

    // Reference detector, evaluated on the bit currently on x_out
    always_comb begin
        det_nx = det_q;
        hit    = 1'b0;
        unique case (det_q)
            S0: det_nx = x_out ? S1 : S0;
            S1: det_nx = x_out ? S1 : S2;
            S2: det_nx = x_out ? S3 : S0;
            S3: begin
                if (x_out) begin
                    hit    = 1'b1;
                    det_nx = S1;
                end else begin
                    det_nx = S2;
                end
            end
            default: det_nx = S0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        det_d    = det_q;
        word_d   = word_q;
        sreg_d   = sreg_q;
        bitcnt_d = bitcnt_q;
        repcnt_d = repcnt_q;
        cnt_d    = match_cnt;
        xo_d     = x_out;
        xv_d     = x_valid;
        busy_d   = busy;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    word_d   = data_in;
                    sreg_d   = data_in;
                    bitcnt_d = LAST;
                    repcnt_d = (repeat_n == '0) ? '0
                                                : repeat_n - CNT_W'(1);
                    det_d    = S0;
                    cnt_d    = '0;
                    xo_d     = data_in[WIDTH-1];
                    xv_d     = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                det_d = det_nx;
                if (hit && (match_cnt != '1)) begin
                    cnt_d = match_cnt + MCW'(1);
                end
                if (bitcnt_q != '0) begin
                    sreg_d   = shifted;
                    xo_d     = shifted[WIDTH-1];
                    bitcnt_d = bitcnt_q - BW'(1);
                end else if (repcnt_q != '0) begin
                    // Reload without a gap; detector state carries over
                    sreg_d   = word_q;
                    xo_d     = word_q[WIDTH-1];
                    bitcnt_d = LAST;
                    repcnt_d = repcnt_q - CNT_W'(1);
                end else begin
                    xo_d    = 1'b0;
                    xv_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                xo_d    = 1'b0;
                xv_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            det_q     <= S0;
            word_q    <= '0;
            sreg_q    <= '0;
            bitcnt_q  <= '0;
            repcnt_q  <= '0;
            match_cnt <= '0;
            x_out     <= 1'b0;
            x_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            det_q     <= det_d;
            word_q    <= word_d;
            sreg_q    <= sreg_d;
            bitcnt_q  <= bitcnt_d;
            repcnt_q  <= repcnt_d;
            match_cnt <= cnt_d;
            x_out     <= xo_d;
            x_valid   <= xv_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
